// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, Op classes,
// DP command codes and ALUControl codes.
`default_nettype none

package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ERR    = 4'd10
   } state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_EOR = 3'd4;

   function automatic logic is_mem_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_dec.sv
// Combinational DP-command decode: ALUControl code, FlagW enables and legality.
`default_nettype none

module alu_dec
   import ctrl_pkg::*;
#(
   parameter int ALU_CW = 3
) (
   input  logic [3:0]        cmd_i,
   input  logic              s_i,
   output logic [ALU_CW-1:0] alu_ctrl_o,
   output logic [1:0]        flag_w_o,
   output logic              legal_o,
   output logic              cmp_o
);

   logic [2:0] code;
   logic       arith;

   always_comb begin
      code    = ALU_ADD;
      arith   = 1'b0;
      legal_o = 1'b1;
      cmp_o   = 1'b0;
      case (cmd_i)
         CMD_ADD: begin code = ALU_ADD; arith = 1'b1; end
         CMD_SUB: begin code = ALU_SUB; arith = 1'b1; end
         CMD_AND: code = ALU_AND;
         CMD_ORR: code = ALU_ORR;
         CMD_EOR: code = ALU_EOR;
         CMD_CMP: begin code = ALU_SUB; arith = 1'b1; cmp_o = 1'b1; end
         default: legal_o = 1'b0;
      endcase
      alu_ctrl_o = ALU_CW'(code);
      // CMP always updates all flags regardless of its S bit
      flag_w_o   = cmp_o ? 2'b11 : {s_i, s_i & arith};
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// Multi-cycle processor control FSM with memory handshake, wait timeout and
// registered datapath controls (IRWrite/NextPC qualify the fetch handshake).
`default_nettype none

module mc_controller
   import ctrl_pkg::*;
#(
   parameter int ALU_CW   = 3,
   parameter int WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        Op,
   input  logic [5:0]        Funct,
   input  logic [3:0]        Rd,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              IRWrite,
   output logic              NextPC,
   output logic              RegW,
   output logic              MemW,
   output logic              PCS,
   output logic              AdrSrc,
   output logic [1:0]        ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ResultSrc,
   output logic [1:0]        ImmSrc,
   output logic [1:0]        RegSrc,
   output logic [1:0]        FlagW,
   output logic [ALU_CW-1:0] ALUControl,
   output logic              undef,
   output logic              timeout
);

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   state_e            state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic [ALU_CW-1:0] dec_alu;
   logic [1:0]        dec_flagw;
   logic              dec_legal, dec_cmp;
   logic              ack, to_evt, wb;

   logic              mem_req_q, adr_src_q, mem_w_q, reg_w_q, pcs_q, undef_q, timeout_q;
   logic              mem_req_d, adr_src_d, mem_w_d, reg_w_d, pcs_d, undef_d, timeout_d;
   logic [1:0]        src_a_q, src_b_q, res_src_q, imm_src_q, reg_src_q, flag_w_q;
   logic [1:0]        src_a_d, src_b_d, res_src_d, imm_src_d, reg_src_d, flag_w_d;
   logic [ALU_CW-1:0] alu_ctrl_q, alu_ctrl_d;

   alu_dec #(.ALU_CW(ALU_CW)) u_alu_dec (
      .cmd_i      (Funct[4:1]),
      .s_i        (Funct[0]),
      .alu_ctrl_o (dec_alu),
      .flag_w_o   (dec_flagw),
      .legal_o    (dec_legal),
      .cmp_o      (dec_cmp)
   );

   // A handshake only counts once the request is actually visible on mem_req
   assign ack    = mem_req_q & mem_ready;
   assign to_evt = mem_req_q & ~mem_ready & ((wait_q + 8'd1) == WAIT_LIM);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (ack) state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_DP:   state_d = !dec_legal ? S_ERR : (Funct[5] ? S_EXECI : S_EXECR);
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_ERR;
            endcase
         end
         S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (ack) state_d = S_MEMWB;
         S_MEMWR:  if (ack) state_d = S_FETCH;
         S_EXECR, S_EXECI: state_d = dec_cmp ? S_FETCH : S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
      if (to_evt) state_d = S_ERR;

      if (state_d != state_q)          wait_d = 8'd0;
      else if (mem_req_q & ~mem_ready) wait_d = wait_q + 8'd1;
      else                             wait_d = wait_q;

      wb         = (state_d == S_MEMWB) || (state_d == S_ALUWB);
      mem_req_d  = is_mem_state(state_d);
      adr_src_d  = (state_d == S_MEMRD) || (state_d == S_MEMWR);
      mem_w_d    = (state_d == S_MEMWR);
      reg_w_d    = wb;
      pcs_d      = (state_d == S_BRANCH) || (wb && (Rd == 4'hF));
      undef_d    = (state_d == S_ERR) && !to_evt;
      timeout_d  = to_evt;
      alu_ctrl_d = ALU_CW'(ALU_ADD);
      flag_w_d   = 2'b00;
      if ((state_d == S_EXECR) || (state_d == S_EXECI)) begin
         alu_ctrl_d = dec_alu;
         flag_w_d   = dec_flagw;
      end

      src_a_d   = 2'b00;
      src_b_d   = 2'b00;
      res_src_d = 2'b00;
      case (state_d)
         S_FETCH, S_DECODE: begin src_a_d = 2'b01; src_b_d = 2'b10; res_src_d = 2'b10; end
         S_MEMADR, S_EXECI: src_b_d = 2'b01;
         S_MEMWB:           res_src_d = 2'b01;
         S_BRANCH:          begin src_b_d = 2'b01; res_src_d = 2'b10; end
         default: ;
      endcase

      case (Op)
         OP_MEM:  begin imm_src_d = 2'b01; reg_src_d = {~Funct[0], 1'b0}; end
         OP_BR:   begin imm_src_d = 2'b10; reg_src_d = 2'b01; end
         default: begin imm_src_d = 2'b00; reg_src_d = 2'b00; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         wait_q     <= 8'd0;
         mem_req_q  <= 1'b0;
         adr_src_q  <= 1'b0;
         mem_w_q    <= 1'b0;
         reg_w_q    <= 1'b0;
         pcs_q      <= 1'b0;
         undef_q    <= 1'b0;
         timeout_q  <= 1'b0;
         src_a_q    <= 2'b00;
         src_b_q    <= 2'b00;
         res_src_q  <= 2'b00;
         imm_src_q  <= 2'b00;
         reg_src_q  <= 2'b00;
         flag_w_q   <= 2'b00;
         alu_ctrl_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         mem_req_q  <= mem_req_d;
         adr_src_q  <= adr_src_d;
         mem_w_q    <= mem_w_d;
         reg_w_q    <= reg_w_d;
         pcs_q      <= pcs_d;
         undef_q    <= undef_d;
         timeout_q  <= timeout_d;
         src_a_q    <= src_a_d;
         src_b_q    <= src_b_d;
         res_src_q  <= res_src_d;
         imm_src_q  <= imm_src_d;
         reg_src_q  <= reg_src_d;
         flag_w_q   <= flag_w_d;
         alu_ctrl_q <= alu_ctrl_d;
      end
   end

   assign IRWrite    = (state_q == S_FETCH) & ack;
   assign NextPC     = (state_q == S_FETCH) & ack;
   assign mem_req    = mem_req_q;
   assign AdrSrc     = adr_src_q;
   assign MemW       = mem_w_q;
   assign RegW       = reg_w_q;
   assign PCS        = pcs_q;
   assign undef      = undef_q;
   assign timeout    = timeout_q;
   assign ALUSrcA    = src_a_q;
   assign ALUSrcB    = src_b_q;
   assign ResultSrc  = res_src_q;
   assign ImmSrc     = imm_src_q;
   assign RegSrc     = reg_src_q;
   assign FlagW      = flag_w_q;
   assign ALUControl = alu_ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: ADD, LDR with waits, CMP, undefined Op,
// fetch timeout and reset during a store.
`default_nettype none

module tb_mc_controller;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       mem_ready;
   logic       mem_req, IRWrite, NextPC, RegW, MemW, PCS, AdrSrc, undef, timeout;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
   logic [2:0] ALUControl;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mc_controller #(.ALU_CW(3), .WAIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
      .mem_req(mem_req), .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .PCS(PCS), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FlagW(FlagW),
      .ALUControl(ALUControl), .undef(undef), .timeout(timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [31:0] st();
      return 32'(dut.state_q);
   endfunction

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
      cyc(); cyc();
      chk("rst_state",   st(), 32'(S_FETCH));
      chk("rst_memreq",  32'(mem_req), 0);
      chk("rst_wait",    32'(dut.wait_q), 0);
      chk("rst_flagw",   32'(FlagW), 0);
      chk("rst_regw",    32'(RegW), 0);

      // ADD register, S=1, Rd=2, memory always ready
      rst_n = 1'b1; Op = 2'b00; Funct = 6'b001001; Rd = 4'd2; mem_ready = 1'b1;
      #1;
      chk("post_rst_memreq0", 32'(mem_req), 0);
      chk("post_rst_irw0",    32'(IRWrite), 0);
      cyc();
      chk("add_fetch_state", st(), 32'(S_FETCH));
      chk("add_fetch_req",   32'(mem_req), 1);
      chk("add_fetch_adr",   32'(AdrSrc), 0);
      chk("add_irwrite",     32'(IRWrite), 1);
      chk("add_nextpc",      32'(NextPC), 1);
      cyc();
      chk("add_decode",      st(), 32'(S_DECODE));
      chk("add_dec_irw",     32'(IRWrite), 0);
      cyc();
      chk("add_execr",       st(), 32'(S_EXECR));
      chk("add_aluctl",      32'(ALUControl), 0);
      chk("add_flagw",       32'(FlagW), 3);
      chk("add_exec_regw",   32'(RegW), 0);
      cyc();
      chk("add_aluwb",       st(), 32'(S_ALUWB));
      chk("add_wb_regw",     32'(RegW), 1);
      chk("add_wb_pcs",      32'(PCS), 0);
      chk("add_wb_flagw",    32'(FlagW), 0);
      cyc();
      chk("add_back_fetch",  st(), 32'(S_FETCH));
      chk("add_regw_drop",   32'(RegW), 0);

      // LDR Rd=15 with three wait cycles in MEMRD
      Op = 2'b01; Funct = 6'b011001; Rd = 4'hF;
      cyc();
      chk("ldr_decode",      st(), 32'(S_DECODE));
      chk("ldr_immsrc",      32'(ImmSrc), 1);
      cyc();
      chk("ldr_memadr",      st(), 32'(S_MEMADR));
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (i == 3) mem_ready = 1'b1;
         chk("ldr_memrd",    st(), 32'(S_MEMRD));
         chk("ldr_rd_req",   32'(mem_req), 1);
         chk("ldr_rd_adr",   32'(AdrSrc), 1);
         chk("ldr_rd_memw",  32'(MemW), 0);
      end
      cyc();
      chk("ldr_memwb",       st(), 32'(S_MEMWB));
      chk("ldr_regw",        32'(RegW), 1);
      chk("ldr_pcs",         32'(PCS), 1);
      cyc();
      chk("ldr_fetch",       st(), 32'(S_FETCH));

      // CMP immediate
      Op = 2'b00; Funct = 6'b110101; Rd = 4'd0;
      cyc();
      chk("cmp_decode",      st(), 32'(S_DECODE));
      cyc();
      chk("cmp_execi",       st(), 32'(S_EXECI));
      chk("cmp_aluctl",      32'(ALUControl), 1);
      chk("cmp_flagw",       32'(FlagW), 3);
      chk("cmp_regw_ex",     32'(RegW), 0);
      cyc();
      chk("cmp_fetch",       st(), 32'(S_FETCH));
      chk("cmp_regw_f",      32'(RegW), 0);

      // Undefined Op=11
      Op = 2'b11; Funct = 6'd0;
      cyc();
      chk("und_decode",      st(), 32'(S_DECODE));
      cyc();
      chk("und_err",         st(), 32'(S_ERR));
      chk("und_undef",       32'(undef), 1);
      chk("und_timeout",     32'(timeout), 0);
      chk("und_regw",        32'(RegW), 0);
      cyc();
      chk("und_fetch",       st(), 32'(S_FETCH));
      chk("und_undef_drop",  32'(undef), 0);

      // Fetch never acknowledged: timeout after WAIT_MAX=4 cycles
      mem_ready = 1'b0; Op = 2'b00;
      for (int i = 1; i < 4; i++) begin
         cyc();
         chk("to_fetch_hold", st(), 32'(S_FETCH));
         chk("to_wait_cnt",   32'(dut.wait_q), 32'(i));
         chk("to_no_pulse",   32'(timeout), 0);
      end
      cyc();
      chk("to_err",          st(), 32'(S_ERR));
      chk("to_timeout",      32'(timeout), 1);
      chk("to_undef",        32'(undef), 0);
      cyc();
      chk("to_fetch",        st(), 32'(S_FETCH));
      chk("to_pulse_drop",   32'(timeout), 0);

      // STR interrupted by reset while in MEMWR
      mem_ready = 1'b1; Op = 2'b01; Funct = 6'b010000; Rd = 4'd3;
      cyc();
      chk("str_decode",      st(), 32'(S_DECODE));
      chk("str_regsrc",      32'(RegSrc), 2);
      mem_ready = 1'b0;
      cyc();
      chk("str_memadr",      st(), 32'(S_MEMADR));
      cyc();
      chk("str_memwr",       st(), 32'(S_MEMWR));
      chk("str_memw",        32'(MemW), 1);
      chk("str_req",         32'(mem_req), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_memw",    32'(MemW), 0);
      chk("rst_mid_req",     32'(mem_req), 0);
      chk("rst_mid_state",   st(), 32'(S_FETCH));
      mem_ready = 1'b1;
      cyc();
      rst_n = 1'b1;
      #1;
      chk("rel_req0",        32'(mem_req), 0);
      cyc();
      chk("rel_req1",        32'(mem_req), 1);
      chk("rel_state",       st(), 32'(S_FETCH));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ALU_CW, default 3: ALUControl width, must be >= 3.
REQ-002 SHALL have parameter WAIT_MAX, default 15: maximum memory wait cycles before timeout, 1..255.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port Op, input, 2: instruction class from the instruction register.
REQ-006 SHALL have port Funct, input, 6: function field, I/cmd/S.
REQ-007 SHALL have port Rd, input, 4: destination register.
REQ-008 SHALL have port mem_ready, input, 1: memory completes the current access.
REQ-009 SHALL have port mem_req, output, 1: memory access request.
REQ-010 SHALL have port IRWrite, output, 1: instruction register load.
REQ-011 SHALL have port NextPC, output, 1: PC advance.
REQ-012 SHALL have ports RegW, MemW and PCS, output, 1 each: register write, memory write and PC-write-from-result.
REQ-013 SHALL have ports AdrSrc, output, 1; ALUSrcA, output, 2; ALUSrcB, output, 2; ResultSrc, output, 2: datapath muxes.
REQ-014 SHALL have ports ImmSrc, output, 2; RegSrc, output, 2; FlagW, output, 2; ALUControl, output, ALU_CW.
REQ-015 SHALL have ports undef and timeout, output, 1 each: one-cycle error pulses.

Function
REQ-016 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ERR; one transition per clk.
REQ-017 In FETCH SHALL assert mem_req and AdrSrc=0; on mem_ready it SHALL assert IRWrite and NextPC for that cycle only and go to DECODE; otherwise it SHALL hold.
REQ-018 From DECODE SHALL go as follows: Op=00 with Funct[5]=1 -> EXECI; Op=00 with Funct[5]=0 -> EXECR; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> ERR.
REQ-019 In DECODE, a DP command outside ADD(0100), SUB(0010), AND(0000), ORR(1100), EOR(0001) and CMP(1010) SHALL go to ERR.
REQ-020 From MEMADR SHALL go to MEMRD if Funct[0]=1, otherwise to MEMWR.
REQ-021 MEMRD and MEMWR SHALL assert mem_req and AdrSrc=1; MemW SHALL be asserted in MEMWR only; each SHALL hold until mem_ready.
REQ-022 On mem_ready, MEMRD SHALL go to MEMWB and MEMWR SHALL go to FETCH.
REQ-023 A wait counter SHALL count cycles spent in any mem_req state without mem_ready; reaching WAIT_MAX SHALL go to ERR with timeout pulsed; the counter SHALL clear on every state change.
REQ-024 MEMWB, ALUWB and BRANCH SHALL assert RegW (BRANCH: PC only, via PCS) for exactly one cycle, then go to FETCH.
REQ-025 EXECR and EXECI SHALL go to ALUWB, except CMP, which SHALL go to FETCH with no RegW.
REQ-026 ALUControl SHALL be ADD=0, SUB=1, AND=2, ORR=3, EOR=4, CMP=1, zero-extended to ALU_CW, valid only in EXECR/EXECI; it SHALL be ADD in every other state.
REQ-027 FlagW[1] SHALL equal Funct[0] and FlagW[0] SHALL equal Funct[0] AND (ADD|SUB|CMP), in EXECR/EXECI only; CMP SHALL force FlagW=11; FlagW SHALL be 00 elsewhere.
REQ-028 PCS SHALL be 1 in BRANCH, or in MEMWB/ALUWB when Rd=1111.
REQ-029 ImmSrc and RegSrc SHALL follow: DP 00/00, LDR 01/x0, STR 01/10, B 10/x1.
REQ-030 ERR SHALL pulse undef (unless timeout was the cause), assert no write enable, and go to FETCH.

Reset
REQ-031 While rst_n=0, state SHALL be FETCH, the wait counter 0, and mem_req, IRWrite, NextPC, RegW, MemW, PCS, undef, timeout and FlagW all 0.
REQ-032 All other outputs SHALL be 0 during reset.
REQ-033 Reset asserted mid-access SHALL abort immediately; the first mem_req SHALL come one clk after rst_n deasserts.

Structure
REQ-034 The state enum, ALUControl codes, DP command codes and Op codes SHALL live in the shared package ctrl_pkg.
REQ-035 The combinational DP-command-to-ALUControl/FlagW map SHALL be sub-module alu_dec.

Verification
REQ-036 Bench SHALL check ADD reg with S=1, mem_ready=1: FETCH, DECODE, EXECR, ALUWB, 4 cycles; ALUControl=0, FlagW=11, RegW pulse in ALUWB.
REQ-037 Bench SHALL check LDR with Rd=15 and mem_ready delayed 3 cycles in MEMRD: MEMRD lasts 4 cycles, then MEMWB with RegW=1, PCS=1.
REQ-038 Bench SHALL check CMP imm: FlagW=11, ALUControl=1, returns to FETCH with RegW never 1.
REQ-039 Bench SHALL check Op=11: DECODE, ERR with undef=1, then FETCH.
REQ-040 Bench SHALL check mem_ready held 0 in FETCH with WAIT_MAX=4: timeout pulse after 4 cycles, ERR, then FETCH.
REQ-041 Bench SHALL check rst_n low during MEMWR: MemW drops within the same cycle, state=FETCH.
